// File: rtl/avr_irq_prio_ctrl.sv
// Fixed-priority interrupt controller between the peripheral irq lines and the core.
// The lowest eligible index wins, as in the AVR vector order. The winning index is
// presented to the core as irq_vector. When the core takes it, that index is
// acknowledged back to the peripherals. Further requests are then held off for
// ACK_GAP cycles so the peripheral flags can settle.
//
// state | meaning
// IDLE  | present the winning line, wait for irq_take
// ACK   | one-cycle irqack carrying the captured index
// GAP   | irq_req held low while the gap down-counter runs to zero
module avr_irq_prio_ctrl #(
  parameter int                   NUM_IRQ  = 45,
  parameter logic [NUM_IRQ-1:0]   IRQ_MASK = {NUM_IRQ{1'b1}},
  parameter int                   ACK_GAP  = 2
) (
  input  logic               cp2,
  input  logic               ireset,
  input  logic [NUM_IRQ-1:0] irqlines,
  input  logic               global_ie,
  input  logic               irq_take,
  output logic               irq_req,
  output logic [5:0]         irq_vector,
  output logic               irqack,
  output logic [5:0]         irqackad,
  output logic               spurious_take
);

  localparam int CW = 8;

  // The index must fit in 6 bits, and the gap must fit in the counter.
  if (NUM_IRQ > 64) begin : g_num_irq_check
    $error("avr_irq_prio_ctrl: NUM_IRQ must not exceed 64");
  end
  if (ACK_GAP < 0 || ACK_GAP > 255) begin : g_ack_gap_check
    $error("avr_irq_prio_ctrl: ACK_GAP must be in 0..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [5:0]        vec_q, vec_d;
  logic              ack_q, ack_d;
  logic [5:0]        ackad_q, ackad_d;
  logic              spur_q, spur_d;

  logic [NUM_IRQ-1:0] eligible;
  logic               any_eligible;
  logic [5:0]         winner;

  // Mask the lines and find the lowest eligible index. Bit 0 is the reset vector.
  always_comb begin
    eligible     = irqlines & IRQ_MASK;
    eligible[0]  = 1'b0;
    any_eligible = |eligible;
    winner       = 6'd0;
    for (int i = NUM_IRQ - 1; i >= 1; i--) begin
      if (eligible[i]) winner = 6'(i);
    end
  end

  // Compute the next state and the registered outputs.
  // irq_req and irq_vector are refreshed whenever the next state is IDLE. The request
  // therefore reappears on the first IDLE cycle after the gap, not one cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    vec_d   = vec_q;
    ack_d   = 1'b0;
    ackad_d = ackad_q;
    spur_d  = spur_q;

    case (state_q)
      IDLE: begin
        if (irq_take) begin
          if (req_q) begin
            state_d = ACK;
            ack_d   = 1'b1;
            ackad_d = vec_q;
          end else begin
            spur_d = 1'b1;
          end
        end
      end
      ACK: begin
        if (ACK_GAP == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          cnt_d   = CW'(ACK_GAP);
        end
      end
      GAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      req_d = global_ie & any_eligible;
      if (any_eligible) vec_d = winner;
    end
  end

  // State and output registers. Reset abandons any handshake in progress.
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      vec_q   <= 6'd0;
      ack_q   <= 1'b0;
      ackad_q <= 6'd0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      ack_q   <= ack_d;
      ackad_q <= ackad_d;
      spur_q  <= spur_d;
    end
  end

  assign irq_req       = req_q;
  assign irq_vector    = vec_q;
  assign irqack        = ack_q;
  assign irqackad      = ackad_q;
  assign spurious_take = spur_q;

endmodule
